multicycle_control: RTL and testbench

Multi-cycle control FSM for the RV64 core. It sequences fetch, decode, execute, memory and writeback over shared ALU, memory and register-file resources for lw, sw, beq and R-type instructions. It waits on a memory ready handshake and traps on illegal opcodes or memory timeout. It drives the mux selects that route the sign-extended immediate into the ALU, and it counts retired instructions.

---
 rtl/multicycle_control.sv | 214 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control FSM for the RV64 core
//
// Purpose: sequences fetch/decode/execute/memory/writeback for lw, sw, beq
// and R-type over shared ALU, memory and register-file resources. It waits
// on the memory ready handshake, traps on an illegal opcode or a memory
// timeout, and counts retired instructions.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   opcode            instruction register bits [6:0]
//   zero, mem_ready   ALU zero flag, memory access done this cycle
//   pc_write..pc_src  datapath enables and mux selects (combinational)
//   trap, trap_cause  halted in TRAP and why (01 illegal, 10 timeout)
//   state             current state encoding for debug
//   retired           completed-instruction counter (wraps)
module multicycle_control #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd9
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic [1:0]        r_trap_cause;
  logic [1:0]        w_cause;
  logic [CNT_W-1:0]  r_retired;
  logic              w_retire;
  logic              w_is_wait;
  logic              w_timeout;

  // Waiting states are the only places mem_ready is looked at.
  assign w_is_wait = ((r_state == S_FETCH) || (r_state == S_MEM_READ) ||
                      (r_state == S_MEM_WRITE)) && !mem_ready;
  assign w_timeout = (TIMEOUT != 0) && w_is_wait &&
                     (r_wait == WAIT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_wait       <= '0;
      r_trap_cause <= 2'b00;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next;
      r_trap_cause <= w_cause;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
      if (w_next != r_state) r_wait <= '0;
      else if (w_is_wait && (r_wait != '1)) r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cause    = r_trap_cause;
    w_retire   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 1'b0;
    trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_DECODE: begin
        // Speculatively compute PC + imm so BRANCH finds its target in ALUOut.
        alu_src_b = 2'b10;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_RTYP:      w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          default: begin
            w_next  = S_TRAP;
            w_cause = 2'b01;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          w_next = S_MEM_WB;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = S_FETCH;
        w_retire   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else if (w_timeout) begin
          w_next  = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 1'b1;
        pc_write  = zero;
        w_next    = S_FETCH;
        w_retire  = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        w_next  = S_TRAP;
        w_cause = 2'b01;
      end
    endcase
    // Enables must drop the moment reset rises, not at the next edge.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 1'b0;
      trap       = 1'b0;
    end
  end

  assign state      = r_state;
  assign trap_cause = r_trap_cause;
  assign retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0000011;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_write, ir_write, mem_read, mem_write, i_or_d;
  logic       reg_write, mem_to_reg, alu_src_a, pc_src, trap;
  logic [1:0] alu_src_b, alu_op, trap_cause;
  logic [3:0] state;
  logic [3:0] retired;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] exp_ret = 4'd0;

  multicycle_control #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .trap(trap),
    .trap_cause(trap_cause), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    exp_ret = 4'd0;
    #1;
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    opcode = 7'b0000011;
    #1;
    n_checks++;
    if (mem_read !== 1'b0) begin n_errors++; $display("FAIL reset_mem_read: got %0b expected 0", mem_read); end
    n_checks++;
    if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000) begin n_errors++; $display("FAIL reset_enables: got %b expected 0000", {pc_write, ir_write, reg_write, mem_write}); end
    step();
    n_checks++;
    if (state !== 4'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++;
    if (retired !== 4'd0) begin n_errors++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    n_checks++;
    if (trap_cause !== 2'b00) begin n_errors++; $display("FAIL reset_cause: got %0d expected 0", trap_cause); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_read !== 1'b1) begin n_errors++; $display("FAIL post_reset_fetch: got %0b expected 1", mem_read); end
  endtask

  task automatic test_lw();
    int exp_s[6] = '{0, 1, 2, 3, 4, 0};
    opcode = 7'b0000011;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (state !== 4'(exp_s[i])) begin n_errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      n_checks++;
      if (reg_write !== (exp_s[i] == 4)) begin n_errors++; $display("FAIL lw_reg_write[%0d]: got %0b expected %0b", i, reg_write, exp_s[i] == 4); end
      n_checks++;
      if (mem_to_reg !== (exp_s[i] == 4)) begin n_errors++; $display("FAIL lw_mem_to_reg[%0d]: got %0b expected %0b", i, mem_to_reg, exp_s[i] == 4); end
      if (i == 0) begin
        n_checks++;
        if ({ir_write, pc_write, i_or_d, alu_src_b} !== 5'b11001) begin n_errors++; $display("FAIL lw_fetch_outs: got %b expected 11001", {ir_write, pc_write, i_or_d, alu_src_b}); end
      end
      if (i == 3) begin
        n_checks++;
        if ({mem_read, i_or_d} !== 2'b11) begin n_errors++; $display("FAIL lw_mem_read: got %b expected 11", {mem_read, i_or_d}); end
      end
      if (i < 5) step();
    end
    exp_ret = exp_ret + 4'd1;
    n_checks++;
    if (retired !== exp_ret) begin n_errors++; $display("FAIL lw_retired: got %0d expected %0d", retired, exp_ret); end
  endtask

  task automatic test_beq();
    opcode = 7'b1100011;
    mem_ready = 1'b1;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      step();
      #1;
      n_checks++;
      if ({alu_src_a, alu_src_b} !== 3'b010) begin n_errors++; $display("FAIL beq_decode_srcs: got %b expected 010", {alu_src_a, alu_src_b}); end
      step();
      #1;
      n_checks++;
      if (state !== 4'd8) begin n_errors++; $display("FAIL beq_state: got %0d expected 8", state); end
      n_checks++;
      if (pc_write !== z[0]) begin n_errors++; $display("FAIL beq_pc_write z=%0d: got %0b expected %0b", z, pc_write, z[0]); end
      n_checks++;
      if ({pc_src, alu_op, alu_src_a} !== 4'b1011) begin n_errors++; $display("FAIL beq_selects: got %b expected 1011", {pc_src, alu_op, alu_src_a}); end
      step();
      exp_ret = exp_ret + 4'd1;
      n_checks++;
      if (state !== 4'd0 || retired !== exp_ret) begin n_errors++; $display("FAIL beq_retire: got state %0d retired %0d expected 0 %0d", state, retired, exp_ret); end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_wait();
    opcode = 7'b0100011;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      n_checks++;
      if ({state, mem_write, i_or_d} !== {4'd5, 2'b11}) begin n_errors++; $display("FAIL sw_wait[%0d]: got state %0d mw %0b iod %0b expected 5 1 1", i, state, mem_write, i_or_d); end
      n_checks++;
      if (retired !== exp_ret) begin n_errors++; $display("FAIL sw_wait_retired[%0d]: got %0d expected %0d", i, retired, exp_ret); end
      step();
    end
    exp_ret = exp_ret + 4'd1;
    n_checks++;
    if (state !== 4'd0 || retired !== exp_ret) begin n_errors++; $display("FAIL sw_retire: got state %0d retired %0d expected 0 %0d", state, retired, exp_ret); end
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111;
    mem_ready = 1'b1;
    step();
    step();
    for (int i = 0; i < 20; i++) begin
      #1;
      n_checks++;
      if ({state, trap, trap_cause} !== {4'd9, 1'b1, 2'b01}) begin n_errors++; $display("FAIL illegal_trap[%0d]: got state %0d trap %0b cause %0d expected 9 1 1", i, state, trap, trap_cause); end
      n_checks++;
      if ({pc_write, ir_write, mem_read, mem_write, reg_write} !== 5'b00000) begin n_errors++; $display("FAIL illegal_enables[%0d]: got %b expected 00000", i, {pc_write, ir_write, mem_read, mem_write, reg_write}); end
      n_checks++;
      if (retired !== exp_ret) begin n_errors++; $display("FAIL illegal_retired[%0d]: got %0d expected %0d", i, retired, exp_ret); end
      step();
    end
    do_reset();
  endtask

  task automatic test_timeout();
    opcode = 7'b0000011;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (state !== 4'd0) begin n_errors++; $display("FAIL timeout_wait[%0d]: got %0d expected 0", i, state); end
    end
    step();
    n_checks++;
    if ({state, trap, trap_cause} !== {4'd9, 1'b1, 2'b10}) begin n_errors++; $display("FAIL timeout_trap: got state %0d trap %0b cause %0d expected 9 1 2", state, trap, trap_cause); end
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    mem_ready = 1'b1;
    step();
    n_checks++;
    if ({state, trap, trap_cause} !== {4'd1, 1'b0, 2'b00}) begin n_errors++; $display("FAIL timeout_rescue: got state %0d trap %0b cause %0d expected 1 0 0", state, trap, trap_cause); end
  endtask

  task automatic test_back_to_back_wrap();
    do_reset();
    opcode = 7'b0110011;
    mem_ready = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      step();
      step();
      n_checks++;
      if ({state, alu_op, alu_src_a, alu_src_b} !== {4'd6, 2'b10, 1'b1, 2'b00}) begin n_errors++; $display("FAIL rtype_execute[%0d]: got state %0d op %0d expected 6 2", n, state, alu_op); end
      step();
      step();
      exp_ret = exp_ret + 4'd1;
      n_checks++;
      if (state !== 4'd0 || retired !== exp_ret) begin n_errors++; $display("FAIL rtype_retire[%0d]: got state %0d retired %0d expected 0 %0d", n, state, retired, exp_ret); end
    end
    n_checks++;
    if (retired !== 4'd0) begin n_errors++; $display("FAIL retired_wrap: got %0d expected 0", retired); end
  endtask

  task automatic test_reset_mid();
    opcode = 7'b0000011;
    mem_ready = 1'b1;
    step();
    step();
    step();
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if ({state, mem_read, i_or_d} !== {4'd3, 2'b11}) begin n_errors++; $display("FAIL mid_before: got state %0d mr %0b iod %0b expected 3 1 1", state, mem_read, i_or_d); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_read, i_or_d, state} !== {2'b00, 4'd0}) begin n_errors++; $display("FAIL mid_async: got mr %0b iod %0b state %0d expected 0 0 0", mem_read, i_or_d, state); end
    n_checks++;
    if (retired !== 4'd0) begin n_errors++; $display("FAIL mid_retired: got %0d expected 0", retired); end
    @(posedge clk);
    #2;
    reset = 1'b0;
    mem_ready = 1'b1;
    #1;
    n_checks++;
    if ({state, mem_read} !== {4'd0, 1'b1}) begin n_errors++; $display("FAIL mid_release: got state %0d mr %0b expected 0 1", state, mem_read); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_sw_wait();
    test_illegal();
    test_timeout();
    test_back_to_back_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
